// File: rtl/uart_rx_controller.sv
// uart_rx_controller: oversampled UART receiver, LSB-first, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting at mid-bit.
module uart_rx_controller #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_clk_en,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 double_stop_bit,
   input  logic                 rx_queue_full,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_queue_we,
   output logic                 overrun_err,
   output logic                 rx_busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t               state, state_n;
   logic [TW-1:0]        tcnt, tcnt_n;
   logic [BW-1:0]        bcnt, bcnt_n;
   logic                 armed, armed_n;
   logic                 rx_meta, rx_sync;
   logic                 bit_val, dec_pt, end_pt;
   logic                 confirm, shift, par_dec, stop_dec, complete;
   logic [DATA_BITS-1:0] shreg;
   logic                 cfg_par_en, cfg_odd, cfg_two;
   logic                 perr, ferr, done;

   assign dec_pt = tcnt == T_MID;
   assign end_pt = tcnt == T_LAST;

`ifdef UART_RX_MAJORITY_EN
   logic s_m2, s_m1;
   always_ff @(posedge clk) begin
      if (reset) begin
         s_m2 <= 1'b1;
         s_m1 <= 1'b1;
      end else if (rx_clk_en) begin
         if (tcnt == T_MID - TW'(2)) s_m2 <= rx_sync;
         if (tcnt == T_MID - TW'(1)) s_m1 <= rx_sync;
      end
   end
   assign bit_val = (s_m2 & s_m1) | (s_m2 & rx_sync) | (s_m1 & rx_sync);
`else
   assign bit_val = rx_sync;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tcnt  <= '0;
         bcnt  <= '0;
         armed <= 1'b1;
      end else begin
         state <= state_n;
         tcnt  <= tcnt_n;
         bcnt  <= bcnt_n;
         armed <= armed_n;
      end
   end

   always_comb begin
      state_n  = state;
      tcnt_n   = tcnt;
      bcnt_n   = bcnt;
      armed_n  = armed;
      confirm  = 1'b0;
      shift    = 1'b0;
      par_dec  = 1'b0;
      stop_dec = 1'b0;
      complete = 1'b0;
      if (rx_clk_en) begin
         tcnt_n = tcnt + 1'b1;
         case (state)
            IDLE: begin
               tcnt_n = '0;
               if (rx_sync) armed_n = 1'b1;
               else if (armed) begin
                  state_n = START;
                  tcnt_n  = TW'(1);
               end
            end
            START: begin
               if (dec_pt && bit_val) begin
                  state_n = IDLE;
                  tcnt_n  = '0;
               end
               confirm = dec_pt && !bit_val;
               if (end_pt) begin
                  state_n = DATA;
                  bcnt_n  = '0;
               end
            end
            DATA: begin
               shift = dec_pt;
               if (end_pt) begin
                  bcnt_n = bcnt + 1'b1;
                  if (bcnt == B_LAST) state_n = cfg_par_en ? PARITY : STOP1;
               end
            end
            PARITY: begin
               par_dec = dec_pt;
               if (end_pt) state_n = STOP1;
            end
            STOP1: begin
               stop_dec = dec_pt;
               complete = dec_pt && !cfg_two;
               if (end_pt) state_n = STOP2;
            end
            STOP2: begin
               stop_dec = dec_pt;
               complete = dec_pt;
            end
            default: state_n = IDLE;
         endcase
         // a low final stop sample disarms so a held-low line yields one frame only
         if (complete) begin
            state_n = IDLE;
            tcnt_n  = '0;
            armed_n = bit_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta       <= 1'b1;
         rx_sync       <= 1'b1;
         shreg         <= '0;
         cfg_par_en    <= 1'b0;
         cfg_odd       <= 1'b0;
         cfg_two       <= 1'b0;
         perr          <= 1'b0;
         ferr          <= 1'b0;
         done          <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_queue_we   <= 1'b0;
         overrun_err   <= 1'b0;
         rx_busy       <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         if (confirm) begin
            cfg_par_en <= parity_en;
            cfg_odd    <= parity_odd;
            cfg_two    <= double_stop_bit;
            perr       <= 1'b0;
            ferr       <= 1'b0;
         end
         if (shift) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
         if (par_dec) perr <= ^shreg ^ bit_val ^ cfg_odd;
         if (stop_dec && !bit_val) ferr <= 1'b1;
         done        <= complete;
         rx_queue_we <= done && !rx_queue_full;
         overrun_err <= done && rx_queue_full;
         if (done && !rx_queue_full) begin
            rx_data       <= shreg;
            rx_parity_err <= perr;
            rx_frame_err  <= ferr;
         end
         rx_busy <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed frames into uart_rx_controller with hand-computed expectations.
module tb_uart_rx_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_clk_en = 1'b1;
   logic       rx = 1'b1;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       double_stop_bit = 1'b0;
   logic       rx_queue_full = 1'b0;
   logic [7:0] rx_data;
   logic       rx_parity_err, rx_frame_err, rx_queue_we, overrun_err, rx_busy;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, t_fall = 0, w_cyc = 0;
   int we_cnt = 0, ov_cnt = 0, w0 = 0, o0 = 0;

   uart_rx_controller #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk(clk), .reset(reset), .rx_clk_en(rx_clk_en), .rx(rx),
      .parity_en(parity_en), .parity_odd(parity_odd), .double_stop_bit(double_stop_bit),
      .rx_queue_full(rx_queue_full), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
      .rx_frame_err(rx_frame_err), .rx_queue_we(rx_queue_we), .overrun_err(overrun_err),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_queue_we) begin
         we_cnt = we_cnt + 1;
         w_cyc  = cyc;
      end
      if (overrun_err) ov_cnt = ov_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic s1, input logic two, input logic s2);
      t_fall = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (pen) bit_time(pbit);
      bit_time(s1);
      if (two) bit_time(s2);
      rx = 1'b1;
   endtask

   task automatic expect_write(input string tag, input logic [7:0] d, input logic pe, input logic fe);
      check({tag, "_cnt"}, we_cnt - w0, 1);
      check({tag, "_data"}, rx_data, d);
      check({tag, "_perr"}, rx_parity_err, pe);
      check({tag, "_ferr"}, rx_frame_err, fe);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("rst_we", rx_queue_we, 0);
      check("rst_ov", overrun_err, 0);
      check("rst_busy", rx_busy, 0);
      check("rst_data", rx_data, 0);
      check("rst_flags", {rx_parity_err, rx_frame_err}, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // 8N1 0xA5
      w0 = we_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("a5", 8'hA5, 1'b0, 1'b0);
      check("a5_latency", w_cyc - t_fall, 156);
      check("a5_busy", rx_busy, 0);

      // 8E1 parity cases
      parity_en = 1'b1;
      w0 = we_cnt;
      send_frame(8'h37, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("e_ok", 8'h37, 1'b0, 1'b0);
      w0 = we_cnt;
      send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("e_bad", 8'h37, 1'b1, 1'b0);
      parity_odd = 1'b1;
      w0 = we_cnt;
      send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("o_ok", 8'h37, 1'b0, 1'b0);
      parity_en = 1'b0;
      parity_odd = 1'b0;
      repeat (20) @(negedge clk);

      // glitch then 0x3C
      w0 = we_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      check("glitch_busy_hi", rx_busy, 1);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_busy_lo", rx_busy, 0);
      check("glitch_nowrite", we_cnt - w0, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("after_glitch", 8'h3C, 1'b0, 1'b0);

      // break: 30 bit times low
      w0 = we_cnt;
      rx = 1'b0;
      repeat (30 * 16) @(negedge clk);
      check("break_cnt", we_cnt - w0, 1);
      check("break_data", rx_data, 8'h00);
      check("break_ferr", rx_frame_err, 1);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      w0 = we_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("after_break", 8'h55, 1'b0, 1'b0);

      // overrun then back-to-back frame
      w0 = we_cnt;
      o0 = ov_cnt;
      rx_queue_full = 1'b1;
      send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("ovr_nowrite", we_cnt - w0, 0);
      check("ovr_pulse", ov_cnt - o0, 1);
      check("ovr_data_held", rx_data, 8'h55);
      rx_queue_full = 1'b0;
      send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      expect_write("b2b", 8'h34, 1'b0, 1'b0);
      check("b2b_ov", ov_cnt - o0, 1);

      // 8O2 with second stop low
      parity_en = 1'b1;
      parity_odd = 1'b1;
      double_stop_bit = 1'b1;
      w0 = we_cnt;
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      expect_write("o2", 8'hFF, 1'b0, 1'b1);
      repeat (32) @(negedge clk);

      // reset mid-DATA
      w0 = we_cnt;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("mid_busy", rx_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", rx_busy, 0);
      check("mid_rst_data", rx_data, 0);
      check("mid_rst_flags", {rx_parity_err, rx_frame_err, rx_queue_we, overrun_err}, 0);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      check("mid_rst_nowrite", we_cnt - w0, 0);
      check("mid_rst_idle", rx_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
